// File: rtl/irq_pkg.sv
// Shared types and sizing rules for the irq_ctrl interrupt controller.
package irq_pkg;

  localparam int DEF_NUM_SRC = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // One extra code point is reserved for the timer source at index NUM_SRC.
  function automatic int irq_id_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational lowest-index priority encoder used to pick the winning request.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int WIDTH = DEF_NUM_SRC + 1,
  parameter int ID_W  = irq_id_w(WIDTH - 1)
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan high to low so the last hit, the lowest index, is what remains.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller feeding the single interrupt line of cpu.
// Optional periodic timer source enabled by defining IRQ_TIMER_EN.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
`ifdef IRQ_TIMER_EN
  parameter int TIMER_PERIOD = 1000,
`endif
  localparam int ID_W = irq_id_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] enable,
  input  logic               irq_ack,
  input  logic               irq_complete,
`ifdef IRQ_TIMER_EN
  input  logic               timer_en,
`endif
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC:0]   pending
);

  irq_state_t         state, next_state;
  logic [NUM_SRC-1:0] src_q;
  logic               primed;
  logic               timer_set;
  logic [NUM_SRC:0]   set_vec, clr_vec, req;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               take_req, take_ack;

`ifdef IRQ_TIMER_EN
  logic [31:0] tcount;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                  tcount <= '0;
    else if (!timer_en)                         tcount <= '0;
    else if (tcount == 32'(TIMER_PERIOD - 1))   tcount <= '0;
    else                                        tcount <= tcount + 32'd1;
  end

  assign timer_set = timer_en && (tcount == 32'(TIMER_PERIOD - 1));
`else
  assign timer_set = 1'b0;
`endif

  // src_q resets to 0, so edge detection waits one clock after reset to
  // avoid treating a source that is already high as a fresh edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_q  <= '0;
      primed <= 1'b0;
    end else begin
      src_q  <= src;
      primed <= 1'b1;
    end
  end

  assign set_vec = {timer_set, primed ? (src & ~src_q) : {NUM_SRC{1'b0}}};
  assign clr_vec = take_ack ? ((NUM_SRC + 1)'(1) << irq_id) : '0;
  assign req     = pending & {1'b1, enable};

  // Set is applied after clear so a fresh edge on the acked source survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending <= '0;
    else       pending <= (pending & ~clr_vec) | set_vec;
  end

  irq_prio_enc #(
    .WIDTH (NUM_SRC + 1),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (req),
    .valid (win_valid),
    .id    (win_id)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_valid)    next_state = ASSERT;
      ASSERT:  if (irq_ack)      next_state = SERVICE;
      SERVICE: if (irq_complete) next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  always_comb begin
    take_req = (state == IDLE) && win_valid;
    take_ack = (state == ASSERT) && irq_ack;
  end

  // The request line and ID are registered so cpu sees no input-to-output path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      interrupt <= 1'b0;
      irq_id    <= '0;
    end else if (take_req) begin
      interrupt <= 1'b1;
      irq_id    <= win_id;
    end else if (take_ack) begin
      interrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (covers the timer when IRQ_TIMER_EN is defined).
module tb_irq_ctrl;

  localparam int N    = 8;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    src = '0;
  logic [N-1:0]    enable = '1;
  logic            irq_ack = 1'b0;
  logic            irq_complete = 1'b0;
  logic            timer_en = 1'b0;
  logic            interrupt;
  logic [ID_W-1:0] irq_id;
  logic [N:0]      pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef IRQ_TIMER_EN
  irq_ctrl #(.NUM_SRC(N), .TIMER_PERIOD(10)) dut (
    .clk(clk), .rstn(rstn), .src(src), .enable(enable),
    .irq_ack(irq_ack), .irq_complete(irq_complete), .timer_en(timer_en),
    .interrupt(interrupt), .irq_id(irq_id), .pending(pending)
  );
`else
  irq_ctrl #(.NUM_SRC(N)) dut (
    .clk(clk), .rstn(rstn), .src(src), .enable(enable),
    .irq_ack(irq_ack), .irq_complete(irq_complete),
    .interrupt(interrupt), .irq_id(irq_id), .pending(pending)
  );
`endif

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic complete_pulse();
    irq_complete = 1'b1; tick(); irq_complete = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(2);
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_int got=%0b exp=0", interrupt); end
    checks++; if (irq_id !== 4'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    checks++; if (pending !== 9'h000) begin failures++; $display("FAIL reset_pend got=%h exp=000", pending); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    src[3] = 1'b1; tick(); src[3] = 1'b0;
    checks++; if (pending !== 9'h008) begin failures++; $display("FAIL single_pend got=%h exp=008", pending); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL single_int_early got=%0b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL single_int got=%0b exp=1", interrupt); end
    checks++; if (irq_id !== 4'd3) begin failures++; $display("FAIL single_id got=%0d exp=3", irq_id); end
    ack_pulse();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL single_ack_int got=%0b exp=0", interrupt); end
    checks++; if (pending !== 9'h000) begin failures++; $display("FAIL single_ack_pend got=%h exp=000", pending); end
    complete_pulse();
  endtask

  task automatic test_priority();
    src[5] = 1'b1; src[2] = 1'b1; tick(); src = '0;
    checks++; if (pending !== 9'h024) begin failures++; $display("FAIL prio_pend got=%h exp=024", pending); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL prio_first got=%0b/%0d exp=1/2", interrupt, irq_id); end
    ack_pulse();
    checks++; if (pending !== 9'h020) begin failures++; $display("FAIL prio_ack_pend got=%h exp=020", pending); end
    complete_pulse();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL prio_gap got=%0b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd5) begin failures++; $display("FAIL prio_second got=%0b/%0d exp=1/5", interrupt, irq_id); end
    ack_pulse();
    complete_pulse();
  endtask

  task automatic test_enable();
    enable = 8'hEF;
    src[4] = 1'b1; tick(); src[4] = 1'b0;
    tick(2);
    checks++; if (pending !== 9'h010) begin failures++; $display("FAIL en_pend got=%h exp=010", pending); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL en_masked got=%0b exp=0", interrupt); end
    enable = 8'hFF;
    tick(2);
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd4) begin failures++; $display("FAIL en_fire got=%0b/%0d exp=1/4", interrupt, irq_id); end
    enable = 8'h00;
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd4) begin failures++; $display("FAIL en_drop_hold got=%0b/%0d exp=1/4", interrupt, irq_id); end
    enable = 8'hFF;
    ack_pulse();
    complete_pulse();
  endtask

  task automatic test_service();
    src[6] = 1'b1; tick(); src[6] = 1'b0;
    tick();
    ack_pulse();
    // Edge and stray ack while servicing source 6
    src[1] = 1'b1; irq_ack = 1'b1; tick(); src[1] = 1'b0; irq_ack = 1'b0;
    checks++; if (pending !== 9'h002) begin failures++; $display("FAIL svc_queue got=%h exp=002", pending); end
    tick();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL svc_hold got=%0b exp=0", interrupt); end
    complete_pulse();
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL svc_gap got=%0b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd1) begin failures++; $display("FAIL svc_next got=%0b/%0d exp=1/1", interrupt, irq_id); end
    // Queue source 7, then ack and complete together: only the ack acts
    src[7] = 1'b1; tick(); src[7] = 1'b0;
    irq_ack = 1'b1; irq_complete = 1'b1; tick(); irq_ack = 1'b0; irq_complete = 1'b0;
    tick(2);
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL ack_cmp_same got=%0b exp=0", interrupt); end
    complete_pulse();
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd7) begin failures++; $display("FAIL svc_src7 got=%0b/%0d exp=1/7", interrupt, irq_id); end
    // New edge on source 7 in the ack cycle keeps it pending
    src[7] = 1'b1; irq_ack = 1'b1; tick(); src[7] = 1'b0; irq_ack = 1'b0;
    checks++; if (pending !== 9'h080 || interrupt !== 1'b0) begin failures++; $display("FAIL ack_edge got=%h/%0b exp=080/0", pending, interrupt); end
    complete_pulse();
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd7) begin failures++; $display("FAIL ack_edge_refire got=%0b/%0d exp=1/7", interrupt, irq_id); end
    ack_pulse();
    complete_pulse();
  endtask

  task automatic test_async_reset();
    src[6] = 1'b1; tick(2);
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd6) begin failures++; $display("FAIL rst_setup got=%0b/%0d exp=1/6", interrupt, irq_id); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (interrupt !== 1'b0 || irq_id !== 4'd0 || pending !== 9'h000) begin failures++; $display("FAIL rst_async got=%0b/%0d/%h exp=0/0/000", interrupt, irq_id, pending); end
    @(negedge clk);
    tick();
    rstn = 1'b1;
    tick(4);
    checks++; if (interrupt !== 1'b0 || pending !== 9'h000) begin failures++; $display("FAIL rst_no_spurious got=%0b/%h exp=0/000", interrupt, pending); end
    src = '0;
    tick();
  endtask

  task automatic test_timer();
`ifdef IRQ_TIMER_EN
    timer_en = 1'b1;
    tick(9);
    checks++; if (pending[N] !== 1'b0) begin failures++; $display("FAIL tmr_early got=%0b exp=0", pending[N]); end
    tick();
    checks++; if (pending[N] !== 1'b1) begin failures++; $display("FAIL tmr_wrap got=%0b exp=1", pending[N]); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd8) begin failures++; $display("FAIL tmr_fire got=%0b/%0d exp=1/8", interrupt, irq_id); end
    timer_en = 1'b0;
    ack_pulse();
    checks++; if (pending !== 9'h000) begin failures++; $display("FAIL tmr_ack got=%h exp=000", pending); end
    complete_pulse();
    timer_en = 1'b1;
    tick(9);
    src[0] = 1'b1; tick(); src[0] = 1'b0;
    checks++; if (pending !== 9'h101) begin failures++; $display("FAIL tmr_both got=%h exp=101", pending); end
    tick();
    timer_en = 1'b0;
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd0) begin failures++; $display("FAIL tmr_preempt got=%0b/%0d exp=1/0", interrupt, irq_id); end
    ack_pulse();
    complete_pulse();
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 4'd8) begin failures++; $display("FAIL tmr_after got=%0b/%0d exp=1/8", interrupt, irq_id); end
    ack_pulse();
    complete_pulse();
`else
    timer_en = 1'b1;
    tick(12);
    checks++; if (pending[N] !== 1'b0) begin failures++; $display("FAIL no_tmr_bit got=%0b exp=0", pending[N]); end
    timer_en = 1'b0;
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_enable();
    test_service();
    test_async_reset();
    test_timer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
